// File: rtl/lobo_hybrid_mul_pipe_if.sv
// Operand/product stream bundle for the pipelined hybrid LOBO multiplier.
// The master drives operands and consumes products; the slave is the multiplier.
interface lobo_hybrid_mul_pipe_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_y;
    logic           in_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic           out_mode;

    modport master (
        output in_valid, in_x, in_y, in_mode, out_ready,
        input  in_ready, out_valid, out_p, out_mode
    );

    modport slave (
        input  in_valid, in_x, in_y, in_mode, out_ready,
        output in_ready, out_valid, out_p, out_mode
    );
endinterface

// File: rtl/lobo_hybrid_mul_pipe.sv
// Three-stage pipelined hybrid LOBO signed multiplier.
// Upper multiplier bits go through exact radix-4 Booth; the low TH bits use a
// leading-one approximation. A per-beat mode bit selects a full exact Booth array.
// S1: operand decode, S2: partial products and log terms, S3: final sum into out_p.
module lobo_hybrid_mul_pipe #(
    parameter int W  = 16,
    parameter int TH = 12,
    parameter int Q  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lobo_hybrid_mul_pipe_if.slave bus
);
    localparam int PW  = 2 * W;
    localparam int ND  = W / 2;
    localparam int KXW = $clog2(TH);
    localparam int KYW = $clog2(W);

    genvar gi;

    // Reject illegal parameter combinations at elaboration.
    generate
        if ((W % 2) != 0 || W < 8 || (TH % 2) != 0 || TH < 4 || TH > W - 2 || Q < 1 || Q >= TH) begin : g_param_check
            $fatal(1, "lobo_hybrid_mul_pipe: illegal W/TH/Q combination");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Flow control: one global advance enable for every stage
    // ------------------------------------------------------------------
    logic out_valid_reg;
    logic out_mode_reg;
    logic [PW-1:0] out_p_reg;
    logic advance;

    assign advance       = ~(out_valid_reg & ~bus.out_ready);
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_p     = out_p_reg;
    assign bus.out_mode  = out_mode_reg;

    // ------------------------------------------------------------------
    // S1 decode (combinational, from the input beat)
    // ------------------------------------------------------------------
    logic [W:0]     x_ext;
    logic [ND-1:0]  neg_c;
    logic [ND-1:0]  one_c;
    logic [ND-1:0]  two_c;
    logic           sx_c;
    logic           sy_c;
    logic [TH-1:0]  ax_c;
    logic [W-1:0]   ay_c;
    logic [KXW-1:0] kx_c;
    logic [KYW-1:0] ky_c;
    logic           xt_en_c;

    assign x_ext = {bus.in_x, 1'b0};

    // Booth digit controls; digits below the approximated field are dropped
    // in approximate mode, so the surviving digits see x[TH-1] as overlap bit.
    generate
        for (gi = 0; gi < ND; gi++) begin : g_booth_enc
            logic keep;
            logic b2;
            logic b1;
            logic b0;
            assign keep = bus.in_mode | ((gi >= TH / 2) ? 1'b1 : 1'b0);
            assign b0 = x_ext[2 * gi];
            assign b1 = x_ext[2 * gi + 1];
            assign b2 = x_ext[2 * gi + 2];
            assign neg_c[gi] = keep & b2 & ~(b1 & b0);
            assign one_c[gi] = keep & (b1 ^ b0);
            assign two_c[gi] = keep & ((b2 & ~b1 & ~b0) | (~b2 & b1 & b0));
        end
    endgenerate

    assign sx_c    = bus.in_x[TH-1];
    assign ax_c    = bus.in_x[TH-1:0] ^ {TH{sx_c}};
    assign sy_c    = bus.in_y[W-1];
    assign ay_c    = bus.in_y ^ {W{sy_c}};
    assign xt_en_c = |ay_c[W-1:W/2];

    // Quantised LOD on ax: only bits at or above Q count, otherwise kx = 0.
    always_comb begin
        kx_c = '0;
        for (int i = Q; i < TH; i++) begin
            if (ax_c[i]) kx_c = KXW'(i);
        end
    end

    // LOD on ay over the upper half; only meaningful when xt_en_c is set.
    always_comb begin
        ky_c = '0;
        for (int i = W / 2; i < W; i++) begin
            if (ay_c[i]) ky_c = KYW'(i);
        end
    end

    // ------------------------------------------------------------------
    // S1 registers
    // ------------------------------------------------------------------
    logic           v1_reg;
    logic           mode1_reg;
    logic           s1_reg;
    logic           ax_zero1_reg;
    logic           xt_en1_reg;
    logic [W-1:0]   y1_reg;
    logic [W-1:0]   ay1_reg;
    logic [ND-1:0]  neg1_reg;
    logic [ND-1:0]  one1_reg;
    logic [ND-1:0]  two1_reg;
    logic [TH-1:0]  ax1_reg;
    logic [KXW-1:0] kx1_reg;
    logic [KYW-1:0] ky1_reg;

    // Capture the decoded beat; hold everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg       <= 1'b0;
            mode1_reg    <= 1'b0;
            s1_reg       <= 1'b0;
            ax_zero1_reg <= 1'b0;
            xt_en1_reg   <= 1'b0;
            y1_reg       <= '0;
            ay1_reg      <= '0;
            neg1_reg     <= '0;
            one1_reg     <= '0;
            two1_reg     <= '0;
            ax1_reg      <= '0;
            kx1_reg      <= '0;
            ky1_reg      <= '0;
        end else if (advance) begin
            v1_reg <= bus.in_valid;
            if (bus.in_valid) begin
                mode1_reg    <= bus.in_mode;
                s1_reg       <= sx_c ^ sy_c;
                ax_zero1_reg <= ~|ax_c;
                xt_en1_reg   <= xt_en_c;
                y1_reg       <= bus.in_y;
                ay1_reg      <= ay_c;
                neg1_reg     <= neg_c;
                one1_reg     <= one_c;
                two1_reg     <= two_c;
                ax1_reg      <= ax_c;
                kx1_reg      <= kx_c;
                ky1_reg      <= ky_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 partial products and log-domain terms (combinational)
    // ------------------------------------------------------------------
    logic [PW-1:0]         y_ext;
    logic [ND-1:0][PW-1:0] pp_c;
    logic [TH-1:0]         rx_c;
    logic [PW-1:0]         yt_mag;
    logic [PW-1:0]         xt_mag;
    logic [PW-1:0]         yt_c;
    logic [PW-1:0]         xt_c;

    assign y_ext = {{W{y1_reg[W-1]}}, y1_reg};

    // Negative digits are one's complemented here; the +1 rides as a sign factor.
    generate
        for (gi = 0; gi < ND; gi++) begin : g_booth_pp
            logic [PW-1:0] mag;
            assign mag = one1_reg[gi] ? y_ext : (two1_reg[gi] ? {y_ext[PW-2:0], 1'b0} : '0);
            assign pp_c[gi] = (neg1_reg[gi] ? ~mag : mag) << (2 * gi);
        end
    endgenerate

    // rx clears the leading-one bit (bit 0 when ax is below the threshold).
    assign rx_c   = ax1_reg & ~(TH'(1) << kx1_reg);
    assign yt_mag = {{W{1'b0}}, ay1_reg};
    assign xt_mag = {{(PW - TH){1'b0}}, rx_c};
    // One's complement negation is intentional: -(v+1) rather than -v.
    assign yt_c   = (mode1_reg | ax_zero1_reg) ? '0 : ((s1_reg ? ~yt_mag : yt_mag) << kx1_reg);
    assign xt_c   = (mode1_reg | ~xt_en1_reg) ? '0 : ((s1_reg ? ~xt_mag : xt_mag) << ky1_reg);

    // ------------------------------------------------------------------
    // S2 registers
    // ------------------------------------------------------------------
    logic                  v2_reg;
    logic                  mode2_reg;
    logic [ND-1:0][PW-1:0] pp2_reg;
    logic [ND-1:0]         neg2_reg;
    logic [PW-1:0]         yt2_reg;
    logic [PW-1:0]         xt2_reg;

    // Register partial products, sign factors and shifted terms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_reg    <= 1'b0;
            mode2_reg <= 1'b0;
            pp2_reg   <= '0;
            neg2_reg  <= '0;
            yt2_reg   <= '0;
            xt2_reg   <= '0;
        end else if (advance) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                mode2_reg <= mode1_reg;
                pp2_reg   <= pp_c;
                neg2_reg  <= neg1_reg;
                yt2_reg   <= yt_c;
                xt2_reg   <= xt_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3 reduction and final add
    // ------------------------------------------------------------------
    logic [PW-1:0] sf_c;
    logic [PW-1:0] sum_c;

    // Collect the Booth sign factors at each digit's weight.
    always_comb begin
        sf_c = '0;
        for (int j = 0; j < ND; j++) begin
            sf_c[2 * j] = neg2_reg[j];
        end
    end

    // Sum all rows; wraps naturally mod 2^(2W).
    always_comb begin
        sum_c = yt2_reg + xt2_reg + sf_c;
        for (int j = 0; j < ND; j++) begin
            sum_c = sum_c + pp2_reg[j];
        end
    end

    // Output register; out_p only changes when a valid beat lands in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_mode_reg  <= 1'b0;
            out_p_reg     <= '0;
        end else if (advance) begin
            out_valid_reg <= v2_reg;
            if (v2_reg) begin
                out_mode_reg <= mode2_reg;
                out_p_reg    <= sum_c;
            end
        end
    end
endmodule

// File: tb/tb_lobo_hybrid_mul_pipe.sv
// Bench for lobo_hybrid_mul_pipe: directed vectors, random streaming against an
// arithmetic reference model, backpressure, and reset with beats in flight.
module tb_lobo_hybrid_mul_pipe;
    localparam int W  = 16;
    localparam int TH = 12;
    localparam int Q  = 8;

    localparam logic [15:0] DIR_X [5] = '{16'h8000, 16'h1000, 16'h0300, 16'hFFFF, 16'h0300};
    localparam logic [15:0] DIR_Y [5] = '{16'h8000, 16'h0003, 16'h0100, 16'h0005, 16'hFF00};
    localparam logic        DIR_M [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [31:0] DIR_P [5] = '{32'h40000000, 32'h00003000, 32'h00030000,
                                          32'h00000000, 32'hFFFE0000};

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    lobo_hybrid_mul_pipe_if #(.W(W)) bus ();

    lobo_hybrid_mul_pipe #(.W(W), .TH(TH), .Q(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Index of the most significant set bit of a positive value.
    function automatic int msb_index(input longint v);
        int k = 0;
        while ((v >> (k + 1)) != 0) k++;
        return k;
    endfunction

    // Reference product from the arithmetic definition of both modes.
    function automatic logic [31:0] ref_product(input logic [15:0] x, input logic [15:0] y,
                                                input logic mode);
        longint xs, ys, xl, ax, ay, rx, b, yt, xt;
        int kx, ky;
        bit s;
        xs = longint'(x);
        if (xs >= (longint'(1) << (W - 1))) xs -= (longint'(1) << W);
        ys = longint'(y);
        if (ys >= (longint'(1) << (W - 1))) ys -= (longint'(1) << W);
        if (mode) return 32'(xs * ys);
        xl = longint'(x) % (longint'(1) << TH);
        if (xl >= (longint'(1) << (TH - 1))) xl -= (longint'(1) << TH);
        b  = (xs - xl) * ys;
        ax = (xl < 0) ? -xl - 1 : xl;
        ay = (ys < 0) ? -ys - 1 : ys;
        s  = (xl < 0) != (ys < 0);
        if (ax >= (longint'(1) << Q)) begin
            kx = msb_index(ax);
            rx = ax - (longint'(1) << kx);
        end else begin
            kx = 0;
            rx = (ax / 2) * 2;
        end
        yt = (ax == 0) ? 0 : ((s ? -(ay + 1) : ay) * (longint'(1) << kx));
        if (ay >= (longint'(1) << (W / 2))) begin
            ky = msb_index(ay);
            xt = (s ? -(rx + 1) : rx) * (longint'(1) << ky);
        end else begin
            xt = 0;
        end
        return 32'(b + yt + xt);
    endfunction

    // Random operand biased toward small magnitudes so both LOD branches are hit.
    function automatic logic [15:0] rand_operand();
        logic [15:0] v;
        case ($urandom_range(0, 3))
            0:       v = 16'($urandom_range(0, 700));
            1:       v = 16'd0 - 16'($urandom_range(0, 700));
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out_p !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_p got=%h exp=00000000", bus.out_p);
        end
        checks++;
        if (bus.out_mode !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_mode got=%b exp=0", bus.out_mode);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_out_valid got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_directed();
        int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = DIR_X[i];
            bus.in_y     = DIR_Y[i];
            bus.in_mode  = DIR_M[i];
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            lat = 1;
            while (bus.out_valid !== 1'b1 && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            $display("dir%0d x=%h y=%h mode=%b p=%h lat=%0d", i, DIR_X[i], DIR_Y[i], DIR_M[i],
                     bus.out_p, lat);
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL dir%0d_latency got=%0d exp=3", i, lat);
            end
            checks++;
            if (bus.out_p !== DIR_P[i]) begin
                errors++;
                $display("FAIL dir%0d_out_p got=%h exp=%h", i, bus.out_p, DIR_P[i]);
            end
            checks++;
            if (bus.out_mode !== DIR_M[i]) begin
                errors++;
                $display("FAIL dir%0d_out_mode got=%b exp=%b", i, bus.out_mode, DIR_M[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_single_beat got=%b exp=0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_p[$];
        logic        exp_m[$];
        logic [15:0] x, y;
        logic        m;
        int          sent = 0;
        int          seen = 0;
        int          cyc  = 0;
        bus.out_ready = 1'b1;
        while ((sent < 100 || exp_p.size() != 0) && cyc < 400) begin
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_p.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra_beat got=%h exp=none", bus.out_p);
                end else begin
                    $display("stream beat %0d p=%h mode=%b exp=%h", seen, bus.out_p,
                             bus.out_mode, exp_p[0]);
                    if (bus.out_p !== exp_p[0]) begin
                        errors++;
                        $display("FAIL stream%0d_out_p got=%h exp=%h", seen, bus.out_p, exp_p[0]);
                    end
                    checks++;
                    if (bus.out_mode !== exp_m[0]) begin
                        errors++;
                        $display("FAIL stream%0d_out_mode got=%b exp=%b", seen, bus.out_mode,
                                 exp_m[0]);
                    end
                    void'(exp_p.pop_front());
                    void'(exp_m.pop_front());
                    seen++;
                end
            end
            if (sent < 100) begin
                x = rand_operand();
                y = rand_operand();
                m = (sent % 2) == 1;
                bus.in_valid = 1'b1;
                bus.in_x     = x;
                bus.in_y     = y;
                bus.in_mode  = m;
                exp_p.push_back(ref_product(x, y, m));
                exp_m.push_back(m);
                sent++;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (seen != 100) begin
            errors++;
            $display("FAIL stream_count got=%0d exp=100", seen);
        end
        checks++;
        if (cyc != 103) begin
            errors++;
            $display("FAIL stream_throughput_cycles got=%0d exp=103", cyc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_p[$];
        logic [15:0] x, y;
        logic        m;
        int          consumed = 0;
        for (int c = 0; c < 30; c++) begin
            x = rand_operand();
            y = rand_operand();
            m = 1'(c % 2);
            bus.in_valid  = (c <= 8) ? 1'b1 : 1'b0;
            bus.in_x      = x;
            bus.in_y      = y;
            bus.in_mode   = m;
            bus.out_ready = (c >= 3 && c < 8) ? 1'b0 : 1'b1;
            #1;
            if (c >= 3 && c < 8) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_stall%0d_in_ready got=%b exp=0", c, bus.in_ready);
                end
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stall%0d_out_valid got=%b exp=1", c, bus.out_valid);
                end
                if (exp_p.size() != 0) begin
                    checks++;
                    if (bus.out_p !== exp_p[0]) begin
                        errors++;
                        $display("FAIL bp_stall%0d_out_p got=%h exp=%h", c, bus.out_p, exp_p[0]);
                    end
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                exp_p.push_back(ref_product(x, y, m));
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (exp_p.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_beat got=%h exp=none", bus.out_p);
                end else begin
                    $display("bp beat %0d p=%h exp=%h", consumed, bus.out_p, exp_p[0]);
                    if (bus.out_p !== exp_p[0]) begin
                        errors++;
                        $display("FAIL bp%0d_out_p got=%h exp=%h", consumed, bus.out_p, exp_p[0]);
                    end
                    void'(exp_p.pop_front());
                    consumed++;
                end
            end
            @(posedge clk);
            #1;
            if (c >= 8 && exp_p.size() == 0) break;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (consumed != 4) begin
            errors++;
            $display("FAIL bp_consumed got=%0d exp=4", consumed);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_duplicate got=%b exp=0", bus.out_valid);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        logic [15:0] x, y;
        logic [31:0] exp;
        int          lat;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = rand_operand() | 16'h0001;
            bus.in_y     = rand_operand() | 16'h0001;
            bus.in_mode  = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_flight_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out_p !== 32'h0) begin
            errors++;
            $display("FAIL rst_flight_out_p got=%h exp=00000000", bus.out_p);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_flight_in_ready got=%b exp=1", bus.in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_p !== 32'h0) begin
                errors++;
                $display("FAIL rst_flight_stale%0d got=%b/%h exp=0/00000000", c, bus.out_valid,
                         bus.out_p);
            end
        end
        x = rand_operand();
        y = rand_operand();
        exp = ref_product(x, y, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_mode  = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("rst_flight beat x=%h y=%h p=%h lat=%0d", x, y, bus.out_p, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL rst_flight_latency got=%0d exp=3", lat);
        end
        checks++;
        if (bus.out_p !== exp) begin
            errors++;
            $display("FAIL rst_flight_out_p got=%h exp=%h", bus.out_p, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_streaming();
        test_backpressure();
        test_reset_in_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
